// File: rtl/aes_pkg.sv
// Shared AES-128 constants, types and GF(2^8) helpers used by the inverse-cipher block.
package aes_pkg;
  localparam int NR        = 10;
  localparam int BLOCK_W   = 128;
  localparam int NUM_BYTES = BLOCK_W / 8;

  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [3:0]         rnd_t;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} inv_ctrl_state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse and conveniently maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // Undo the S-box affine map, then invert in the field
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] x;
    x = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(x);
  endfunction
endpackage

// File: rtl/aes_inv_round_prims.sv
// Combinational inverse-round primitives: shift rows, sub bytes, mix columns, add round key.
// Byte i of a block lives at bits [127-8*i -: 8]; AES state is column-major (i = row + 4*col).
module inv_sbox_byte
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);
  assign dout = inv_sbox(din);
endmodule

module inv_sub_bytes
  import aes_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);
  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_byte
    inv_sbox_byte u_sb (
      .din  (din[8*i +: 8]),
      .dout (dout[8*i +: 8])
    );
  end
endmodule

module inv_shift_rows
  import aes_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      // row r rotates right by r columns
      assign dout[127-8*(r+4*c) -: 8] = din[127-8*(r+4*((c-r+4)%4)) -: 8];
    end
  end
endmodule

module inv_mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = din[127-32*c -: 8];
    assign a1 = din[119-32*c -: 8];
    assign a2 = din[111-32*c -: 8];
    assign a3 = din[103-32*c -: 8];
    assign dout[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign dout[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign dout[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign dout[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
  end
endmodule

module inv_add_round_key
  import aes_pkg::*;
(
  input  logic [127:0] din,
  input  logic [127:0] key,
  output logic [127:0] dout
);
  assign dout = din ^ key;
endmodule

// File: rtl/inv_cipher_ctrl_round_key_bank.sv
// Eleven-entry round-key register file: one write port, a fixed read of entry 10 and a rnd-indexed read.
module round_key_bank
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [3:0]   idx,
  input  logic [127:0] data,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_data,
  output logic [127:0] rd10_data
);
  localparam int DEPTH = NR + 1;

  block_t bank_q [DEPTH];
  block_t bank_d [DEPTH];

  // An exact index match per entry drops writes to 11..15 for free
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      bank_d[i] = (we && (idx == rnd_t'(i))) ? data : bank_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= bank_d[i];
    end
  end

  assign rd10_data = bank_q[NR];
  assign rd_data   = (rd_idx <= rnd_t'(NR)) ? bank_q[rd_idx] : '0;
endmodule

// File: rtl/inv_cipher_ctrl.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, rounds 10 down to 0.
module inv_cipher_ctrl
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_we,
  input  logic [3:0]   key_idx,
  input  logic [127:0] key_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  inv_ctrl_state_e fsm_q, fsm_d;
  rnd_t            rnd_q, rnd_d;
  block_t          blk_q, blk_d;

  block_t rk10, rk_rnd;
  block_t isr_out, isb_out, ark_rnd_out, imc_out;
  block_t ark_sh_in, ark_sh_key, ark_sh_out;
  logic   bank_we;

  // The bank only changes between blocks
  assign bank_we = key_we && (fsm_q == IDLE);

  round_key_bank u_bank (
    .clk       (clk),
    .rst       (rst),
    .we        (bank_we),
    .idx       (key_idx),
    .data      (key_data),
    .rd_idx    (rnd_q),
    .rd_data   (rk_rnd),
    .rd10_data (rk10)
  );

  inv_shift_rows u_isr (
    .din  (blk_q),
    .dout (isr_out)
  );

  inv_sub_bytes u_isb (
    .din  (isr_out),
    .dout (isb_out)
  );

  inv_add_round_key u_ark_rnd (
    .din  (isb_out),
    .key  (rk_rnd),
    .dout (ark_rnd_out)
  );

  inv_mix_columns u_imc (
    .din  (ark_rnd_out),
    .dout (imc_out)
  );

  // Entry whitening in IDLE and the last round in FINAL share one adder;
  // rnd has already counted down to 0 by FINAL, so rk_rnd is bank[0] there.
  assign ark_sh_in  = (fsm_q == IDLE) ? in_data : isb_out;
  assign ark_sh_key = (fsm_q == IDLE) ? rk10    : rk_rnd;

  inv_add_round_key u_ark_sh (
    .din  (ark_sh_in),
    .key  (ark_sh_key),
    .dout (ark_sh_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= IDLE;
      rnd_q <= '0;
      blk_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      rnd_q <= rnd_d;
      blk_q <= blk_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    rnd_d     = rnd_q;
    blk_d     = blk_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (fsm_q)
      IDLE: begin
        busy     = 1'b0;
        in_ready = !key_we;
        if (in_valid && !key_we) begin
          blk_d = ark_sh_out;
          rnd_d = rnd_t'(NR - 1);
          fsm_d = ROUND;
        end
      end
      ROUND: begin
        blk_d = imc_out;
        rnd_d = rnd_q - 4'd1;
        if (rnd_q == 4'd1) fsm_d = FINAL;
      end
      FINAL: begin
        blk_d = ark_sh_out;
        fsm_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign out_data = blk_q;
endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// Directed bench for inv_cipher_ctrl against a bench-side AES model (forward cipher + key schedule).
module tb_inv_cipher_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         key_we;
  logic [3:0]   key_idx;
  logic [127:0] key_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] mk    [11];
  logic [127:0] p2, c2, exp_zero;

  localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] JUNK = 128'hdeadbeefcafef00d0123456789abcdef;

  inv_cipher_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .key_we    (key_we),
    .key_idx   (key_idx),
    .key_data  (key_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Forward S-box by brute-force inverse + affine; inverse table by reversing it
  task automatic build_sbox();
    logic [7:0] v, q;
    for (int x = 0; x < 256; x++) begin
      v = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      q = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
      sbox[x]  = q;
      isbox[q] = 8'(x);
    end
  endtask

  function automatic logic [127:0] sb_blk(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? isbox[s[127-8*i -: 8]] : sbox[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shr(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? r + 4*((c - r + 4) % 4) : r + 4*((c + r) % 4);
        o[127-8*(r+4*c) -: 8] = s[127-8*src -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      if (!inv) begin
        o[127-32*c -: 8] = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
        o[119-32*c -: 8] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
        o[111-32*c -: 8] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
        o[103-32*c -: 8] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
      end else begin
        o[127-32*c -: 8] = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
        o[119-32*c -: 8] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
        o[111-32*c -: 8] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
        o[103-32*c -: 8] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
      end
    end
    return o;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ mk[0];
    for (int r = 1; r < 10; r++) s = mix(shr(sb_blk(s, 1'b0), 1'b0), 1'b0) ^ mk[r];
    return shr(sb_blk(s, 1'b0), 1'b0) ^ mk[10];
  endfunction

  function automatic logic [127:0] dec(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ mk[10];
    for (int r = 9; r >= 1; r--) s = mix(sb_blk(shr(s, 1'b1), 1'b1) ^ mk[r], 1'b1);
    return sb_blk(shr(s, 1'b1), 1'b1) ^ mk[0];
  endfunction

  // ---- stimulus helpers ----
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load_keys();
    for (int r = 0; r < 11; r++) begin
      key_we = 1'b1; key_idx = 4'(r); key_data = mk[r];
      step();
    end
    key_we = 1'b0;
  endtask

  task automatic accept(input logic [127:0] ct, input string tag, input logic hold);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_data  = ct;
    #1;
    while (!in_ready && g < 30) begin step(); g++; end
    chk1({tag, "_acc_ready"}, in_ready, 1'b1);
    step();
    acc_cyc = cyc;
    if (!hold) in_valid = 1'b0;
    chk1({tag, "_acc_busy"}, busy, 1'b1);
  endtask

  task automatic wait_out(input string tag, input logic [127:0] exp);
    int g;
    g = 0;
    while (!out_valid && g < 40) begin step(); g++; end
    chk({tag, "_latency"}, 128'(cyc - acc_cyc), 128'd10);
    chk({tag, "_data"}, out_data, exp);
  endtask

  initial begin
    rst = 1'b1; key_we = 1'b0; key_idx = '0; key_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    build_sbox();
    expand(KEY);
    p2 = 128'h3243f6a8885a308d313198a2e0370734;
    c2 = enc(p2);
    #2;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 128'h0);
    chk1("rst_in_ready", in_ready, 1'b1);
    step();
    rst = 1'b0;
    load_keys();

    // C.1 vector, out_ready tied high
    accept(CT1, "c1", 1'b0);
    wait_out("c1", PT1);
    chk1("c1_in_ready_low", in_ready, 1'b0);
    step();
    chk1("c1_hs_out_valid", out_valid, 1'b0);
    chk1("c1_hs_in_ready", in_ready, 1'b1);

    // output backpressure
    out_ready = 1'b0;
    accept(CT1, "bp", 1'b0);
    wait_out("bp", PT1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_data", out_data, PT1);
      chk1("bp_hold_valid", out_valid, 1'b1);
      chk1("bp_hold_in_ready", in_ready, 1'b0);
      step();
    end
    out_ready = 1'b1;
    chk("bp_release_data", out_data, PT1);
    step();
    chk1("bp_hs_out_valid", out_valid, 1'b0);
    chk1("bp_hs_in_ready", in_ready, 1'b1);

    // back-to-back with in_valid held high
    accept(CT1, "b2b1", 1'b1);
    in_data = c2;
    wait_out("b2b1", PT1);
    step();
    chk1("b2b_idle_in_ready", in_ready, 1'b1);
    chk1("b2b_idle_busy", busy, 1'b0);
    step();
    acc_cyc = cyc;
    chk1("b2b_second_accept", busy, 1'b1);
    in_valid = 1'b0;
    wait_out("b2b2", p2);
    step();

    // key write during ROUND is dropped
    accept(CT1, "kwr", 1'b0);
    step(); step();
    key_we = 1'b1; key_idx = 4'd0; key_data = JUNK;
    #1;
    chk1("kwr_in_ready", in_ready, 1'b0);
    step();
    key_we = 1'b0;
    wait_out("kwr", PT1);
    step();

    // key_we in IDLE blocks acceptance; idx 11..15 writes are ignored
    in_valid = 1'b1; in_data = CT1; key_data = JUNK;
    for (int i = 11; i < 16; i++) begin
      key_we = 1'b1; key_idx = 4'(i);
      #1;
      chk1("kidle_in_ready", in_ready, 1'b0);
      step();
      chk1("kidle_no_accept", busy, 1'b0);
    end
    key_we = 1'b0;
    accept(CT1, "kidx", 1'b0);
    wait_out("kidx", PT1);
    step();

    // reset with rnd = 5, then decrypt zero with the cleared bank
    accept(CT1, "rmid", 1'b0);
    repeat (4) step();
    #1 rst = 1'b1;
    #1;
    chk1("rmid_out_valid", out_valid, 1'b0);
    chk1("rmid_busy", busy, 1'b0);
    chk("rmid_out_data", out_data, 128'h0);
    step();
    rst = 1'b0;
    #1;
    chk1("rmid_in_ready", in_ready, 1'b1);
    for (int r = 0; r < 11; r++) mk[r] = '0;
    exp_zero = dec(128'h0);
    accept(128'h0, "zero", 1'b0);
    wait_out("zero", exp_zero);
    step();
    chk1("zero_hs_in_ready", in_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
